log10_fxp: RTL and testbench

- Iterative, clocked fixed-point base-10 logarithm unit for the fixed-point math library.
- Input is a signed two's-complement WI.WF number; output is a signed WIO.WFO number.
- Method: leading-one normalisation, then bit-serial log2 by repeated squaring, then a multiply by the constant log10(2).
- Non-positive inputs are flagged on Negflow.

---
 rtl/log10_fxp.sv | 210 +++++++++++++++++++++
 tb/tb_log10_fxp.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/log10_fxp.sv
// log10_fxp: iterative fixed-point base-10 logarithm.
// Input WI.WF signed, output WIO.WFO signed. The input is normalised to a
// mantissa in [1,2) and log2 is produced one fraction bit per cycle by
// repeated squaring. The result is then scaled by log10(2).
// Non-positive operands skip the iteration and raise Negflow.
// Build option: define LOG10_ROUND_EN to round the final scale to nearest
// (ties away from zero) instead of truncating toward -inf. Latency is the same
// in both builds.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for Start, operand latched on Start
// S_LOAD  | sign/zero check, leading-one search, mantissa normalisation
// S_ITER  | WFO+4 squaring steps, one log2 fraction bit per cycle
// S_SCALE | multiply log2 by log10(2), reduce to WFO fraction bits
// S_OUT   | result registered, Done high for this one cycle
module log10_fxp #(
  parameter int WI  = 8,
  parameter int WF  = 32,
  parameter int WIO = 8,
  parameter int WFO = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [WI+WF-1:0]     NumIn,
  output logic [WIO+WFO-1:0]   Base10,
  output logic                 Negflow,
  output logic                 Busy,
  output logic                 Done
);

  localparam int W   = WI + WF;
  localparam int WO  = WIO + WFO;
  localparam int FF  = WFO + 4;              // log2 fraction bits
  localparam int PW  = $clog2(W);            // leading-one index width
  localparam int KW  = PW + 2;               // signed integer part of log2
  localparam int LW  = KW + FF;              // signed log2 word
  localparam int MW  = LW + FF + 1;          // product width
  localparam int SH  = 2 * FF - WFO;         // bits dropped after the product
  localparam int SQW = 2 * FF + 2;           // mantissa square width
  localparam int CNW = $clog2(FF + 1);

  // log10(2) scaled to FF fraction bits and rounded to nearest.
  localparam real    LOG10_2 = 0.30102999566398120;
  localparam longint C_INT   = longint'(LOG10_2 * (2.0 ** FF));
  localparam logic [FF-1:0] C_LOG = FF'(C_INT);

`ifdef LOG10_ROUND_EN
  localparam logic [MW-1:0] HALF = MW'(1) << (SH - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ITER  = 3'd2,
    S_SCALE = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     num_q, num_d;
  logic [FF:0]      m_q, m_d;
  logic [FF-1:0]    frac_q, frac_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNW-1:0]   cnt_q, cnt_d;
  logic [WO-1:0]    base_q, base_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [PW-1:0]    lead_p;
  logic [W+FF-1:0]  norm_wide;
  logic [FF:0]      m_load;
  logic [KW-1:0]    k_load;
  logic [SQW-1:0]   sq_full;
  logic [FF+1:0]    sq_t;
  logic signed [LW-1:0] l_val;
  logic signed [MW-1:0] prod;
  logic signed [MW-1:0] prod_adj;
  logic signed [MW-1:0] scaled;
  logic [WO-1:0]    base_scaled;
`ifdef LOG10_ROUND_EN
  logic [MW-1:0]    half_v;
`endif

  // Leading-one search over the magnitude bits; highest set bit wins.
  always_comb begin
    lead_p = '0;
    for (int i = 0; i < W - 1; i++) begin
      if (num_q[i]) lead_p = PW'(i);
    end
  end

  // Mantissa normalisation to [1,2) with FF fraction bits, plus log2 integer part.
  always_comb begin
    norm_wide = {num_q, {FF{1'b0}}} >> lead_p;
    m_load    = (FF + 1)'(norm_wide);
    k_load    = KW'(lead_p) - KW'(WF);
  end

  // One squaring step: m*m truncated back to FF fraction bits (range [1,4)).
  always_comb begin
    sq_full = SQW'(m_q) * SQW'(m_q);
    sq_t    = (FF + 2)'(sq_full >> FF);
  end

  // Scale log2 by log10(2) and drop down to WFO fraction bits.
  always_comb begin
    l_val = $signed({k_q, frac_q});
    prod  = MW'(l_val) * MW'($signed({1'b0, C_LOG}));
`ifdef LOG10_ROUND_EN
    // Negative values add one less so an exact half moves away from zero.
    half_v   = prod[MW-1] ? (HALF - MW'(1)) : HALF;
    prod_adj = prod + $signed(half_v);
`else
    prod_adj = prod;
`endif
    scaled      = prod_adj >>> SH;
    base_scaled = WO'(scaled);
  end

  // Next-state and datapath update for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    m_d     = m_q;
    frac_d  = frac_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          num_d   = NumIn;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (num_q[W-1] || (num_q == '0)) begin
          base_d  = '0;
          neg_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_OUT;
        end else begin
          m_d     = m_load;
          k_d     = k_load;
          frac_d  = '0;
          cnt_d   = CNW'(FF - 1);
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (sq_t[FF+1]) m_d = sq_t[FF+1:1];
        else            m_d = sq_t[FF:0];
        frac_d = {frac_q[FF-2:0], sq_t[FF+1]};
        if (cnt_q == '0) state_d = S_SCALE;
        else             cnt_d   = cnt_q - CNW'(1);
      end
      S_SCALE: begin
        base_d  = base_scaled;
        neg_d   = 1'b0;
        done_d  = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // All state and registered outputs; reset aborts any computation in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      m_q     <= '0;
      frac_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      m_q     <= m_d;
      frac_q  <= frac_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Base10  = base_q;
  assign Negflow = neg_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_log10_fxp.sv
// tb_log10_fxp: self-checking bench for log10_fxp.
// Reference values come from real-valued log10 of the operand, with an exact
// integer model for powers of two (log2 fraction is zero there).
`timescale 1ns/1ps
module tb_log10_fxp;

  localparam int WI  = 8;
  localparam int WF  = 32;
  localparam int WIO = 8;
  localparam int WFO = 32;
  localparam int W   = WI + WF;
  localparam int WO  = WIO + WFO;
  localparam int LAT = WFO + 7;
`ifdef LOG10_ROUND_EN
  localparam real TOL = 2.0 ** (-(WFO - 1));
`else
  localparam real TOL = 2.0 ** (-(WFO - 2));
`endif

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Start;
  logic [W-1:0]  NumIn;
  logic [WO-1:0] Base10;
  logic          Negflow;
  logic          Busy;
  logic          Done;

  int n_pass  = 0;
  int n_total = 0;

  int            lat;
  logic          seen;
  logic          busy_ok;
  logic [63:0]   r64;
  logic [W-1:0]  x;

  log10_fxp #(.WI(WI), .WF(WF), .WIO(WIO), .WFO(WFO)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .NumIn   (NumIn),
    .Base10  (Base10),
    .Negflow (Negflow),
    .Busy    (Busy),
    .Done    (Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_tol(input string tag, input real obs, input real expv);
    real  err;
    logic ok;
    err = obs - expv;
    if (err < 0.0) err = -err;
    ok = (err <= TOL);
    n_total++;
    assert (ok === 1'b1) n_pass++;
    else $error("FAIL %s observed=%.12f expected=%.12f", tag, obs, expv);
  endtask

  function automatic real to_real_in(input logic [W-1:0] v);
    return real'(longint'(v)) / (2.0 ** WF);
  endfunction

  function automatic real to_real_out(input logic [WO-1:0] v);
    return real'(longint'($signed(v))) / (2.0 ** WFO);
  endfunction

  function automatic int msb_pos(input logic [W-1:0] v);
    int p;
    p = 0;
    for (int i = 0; i < W; i++) if (v[i]) p = i;
    return p;
  endfunction

  // Exact result for a power-of-two operand: k*C reduced from WFO+4 to WFO bits.
  function automatic logic [WO-1:0] pow2_exp(input int k);
    longint c, y, q;
`ifdef LOG10_ROUND_EN
    longint mag;
`endif
    c = longint'(0.30102999566398120 * (2.0 ** (WFO + 4)));
    y = longint'(k) * c;
`ifdef LOG10_ROUND_EN
    mag = (y < 0) ? -y : y;
    q   = (mag + 8) >>> 4;
    if (y < 0) q = -q;
`else
    q = y >>> 4;
`endif
    return WO'(q);
  endfunction

  // Issue one Start; optionally pulse Start again (with another operand) at poke_at.
  task automatic run_op(input logic [W-1:0] v, input int poke_at, input logic [W-1:0] poke_val,
                        output int l, output logic s, output logic b);
    @(negedge Clk);
    NumIn = v;
    Start = 1'b1;
    @(posedge Clk);
    l = 1;
    #1;
    Start = 1'b0;
    NumIn = '0;
    s = 1'b0;
    b = 1'b1;
    while (!s && l < 3 * LAT) begin
      if (l == poke_at) begin
        Start = 1'b1;
        NumIn = poke_val;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clk);
      l++;
      #1;
      b = b & Busy;
      if (Done) s = 1'b1;
    end
    Start = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [W-1:0] v, input int l,
                          input logic s, input logic b);
    chk({tag, ".done_seen"}, 64'(s), 64'(1));
    chk({tag, ".busy_while_running"}, 64'(b), 64'(1));
    if (v[W-1] || v == '0) begin
      chk({tag, ".negflow"}, 64'(Negflow), 64'(1));
      chk({tag, ".base10_zero"}, 64'(Base10), 64'(0));
      chk({tag, ".short_latency"}, 64'(l <= 4), 64'(1));
    end else begin
      chk({tag, ".latency"}, 64'(l), 64'(LAT));
      chk({tag, ".negflow"}, 64'(Negflow), 64'(0));
      chk_tol({tag, ".value"}, to_real_out(Base10), $log10(to_real_in(v)));
      if ((v & (v - W'(1))) == '0)
        chk({tag, ".pow2_exact"}, 64'(Base10), 64'(pow2_exp(msb_pos(v) - WF)));
    end
    @(posedge Clk);
    #1;
    chk({tag, ".done_one_cycle"}, 64'(Done), 64'(0));
    chk({tag, ".idle_after"}, 64'(Busy), 64'(0));
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] v);
    int   l;
    logic s, b;
    run_op(v, 0, '0, l, s, b);
    check_op(tag, v, l, s, b);
  endtask

  task automatic watch_no_done(input int n, output logic s);
    s = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      if (Done) s = 1'b1;
    end
  endtask

  initial begin
    Rst   = 1'b1;
    Start = 1'b0;
    NumIn = '0;
    #2 Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset.base10",  64'(Base10),  64'(0));
    chk("reset.negflow", 64'(Negflow), 64'(0));
    chk("reset.busy",    64'(Busy),    64'(0));
    chk("reset.done",    64'(Done),    64'(0));
    @(negedge Clk);
    Rst = 1'b1;

    do_op("two",        40'h02_00000000);
    chk("two.value_bits", 64'(Base10), 64'(40'h00_4D104D42));
    do_op("one",        40'h01_00000000);
    chk("one.zero", 64'(Base10), 64'(0));
    do_op("x16_98",     40'h10_FAE147AE);
    do_op("x90_0075",   40'h5A_01EB851E);
    do_op("x0_0001",    40'h00_00068DB8);
    chk("x0_0001.sign", 64'(Base10[WO-1]), 64'(1));
    do_op("lsb",        40'h00_00000001);
    do_op("zero",       40'h00_00000000);
    do_op("most_neg",   40'h80_00000000);
    do_op("sixtyfour",  40'h40_00000000);
    do_op("half",       40'h00_80000000);
    do_op("max_pos",    40'h7F_FFFFFFFF);

    // Start pulsed while busy must be ignored; the first operand's result stands.
    run_op(40'h10_FAE147AE, 10, 40'h02_00000000, lat, seen, busy_ok);
    check_op("start_ignored", 40'h10_FAE147AE, lat, seen, busy_ok);
    watch_no_done(LAT + 5, seen);
    chk("start_ignored.no_extra_done", 64'(seen), 64'(0));

    // Reset in the middle of the iteration clears outputs at once and gives no Done.
    do_op("pre_reset", 40'h5A_01EB851E);
    @(negedge Clk);
    NumIn = 40'h03_00000000;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (12) @(posedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    chk("mid_reset.base10",  64'(Base10),  64'(0));
    chk("mid_reset.negflow", 64'(Negflow), 64'(0));
    chk("mid_reset.busy",    64'(Busy),    64'(0));
    chk("mid_reset.done",    64'(Done),    64'(0));
    @(negedge Clk);
    Rst = 1'b1;
    watch_no_done(LAT + 5, seen);
    chk("mid_reset.no_done", 64'(seen), 64'(0));

    // Back-to-back operations after Done.
    do_op("b2b_a", 40'h00_00068DB8);
    do_op("b2b_b", 40'h10_FAE147AE);
    do_op("b2b_c", 40'h00_00000001);

    for (int i = 0; i < 20; i++) begin
      r64 = {$urandom, $urandom};
      x = W'(r64) >> $urandom_range(1, W - 1);
      if (x == '0) x = W'(1);
      do_op($sformatf("rand_pos%0d", i), x);
    end
    for (int i = 0; i < 4; i++) begin
      r64 = {$urandom, $urandom};
      x = W'(r64);
      x[W-1] = 1'b1;
      do_op($sformatf("rand_neg%0d", i), x);
    end
    for (int i = 0; i < 6; i++) begin
      x = W'(1) << $urandom_range(0, W - 2);
      do_op($sformatf("rand_pow2_%0d", i), x);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
